// File: rtl/seg7_scan_driver_if.sv
// Bundle of the data, control and display signals of seg7_scan_driver.
// master: the datapath/testbench side; slave: the scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] d;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    le;
    logic                    bl_n;
    logic                    lt_n;
    logic                    lzb_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dig_sel;

    modport master (
        output d, dp_in, le, bl_n, lt_n, lzb_en,
        input  seg, dp, dig_sel
    );

    modport slave (
        input  d, dp_in, le, bl_n, lt_n, lzb_en,
        output seg, dp, dig_sel
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit BCD-to-7-segment driver with 4511-style controls.
// Latches NUM_DIGITS nibbles plus decimal points, scans one digit every
// SCAN_DIV clocks and drives registered, polarity-adjusted seg/dp/dig_sel.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int   CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   LAT_W = 5 * NUM_DIGITS;
    localparam logic INV   = (COMMON_ANODE != 0);

    logic [LAT_W-1:0]      latch_q, latch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

    // 4511 decode; codes 10..15 blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7C;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h67;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Latch load/hold and scan counter/digit index advance.
    always_comb begin
        latch_d = bus.le ? latch_q : {bus.dp_in, bus.d};
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Select the active digit, apply lamp test/blank/leading-zero priority
    // and output polarity.
    always_comb begin
        logic [3:0] nib;
        logic       dp_sel;
        logic       lz_blank;
        logic [6:0] seg_l;
        logic       dp_l;

        nib       = '0;
        dp_sel    = 1'b0;
        lz_blank  = (idx_q != '0);
        dig_sel_d = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == idx_q) begin
                nib          = latch_q[4*j +: 4];
                dp_sel       = latch_q[4*NUM_DIGITS + j];
                dig_sel_d[j] = 1'b1;
            end
            // Any non-zero nibble at or above the active digit cancels blanking.
            if (IDX_W'(j) >= idx_q && latch_q[4*j +: 4] != 4'd0) begin
                lz_blank = 1'b0;
            end
        end

        if (!bus.lt_n) begin
            seg_l = 7'h7F;
            dp_l  = 1'b1;
        end else if (!bus.bl_n) begin
            seg_l = 7'h00;
            dp_l  = 1'b0;
        end else if (bus.lzb_en && lz_blank) begin
            seg_l = 7'h00;
            dp_l  = dp_sel;
        end else begin
            seg_l = bcd_to_seg(nib);
            dp_l  = dp_sel;
        end

        seg_d     = seg_l ^ {7{INV}};
        dp_d      = dp_l ^ INV;
        dig_sel_d = dig_sel_d ^ {NUM_DIGITS{INV}};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= {7{INV}};
            dp_q      <= INV;
            dig_sel_q <= {NUM_DIGITS{INV}};
        end else begin
            latch_q   <= latch_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.dig_sel = dig_sel_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit successor to the single-digit 74HC4511-style BCD-to-7-segment decoder. It latches NUM_DIGITS BCD nibbles and time-multiplexes them onto one shared segment bus with a one-hot digit-select output. It keeps the 4511 controls (latch enable, blanking, lamp test) and adds leading-zero blanking, per-digit decimal points, a programmable scan rate and output polarity. It sits between the numeric datapath (counters, BCD converters) and the board's multiplexed LED display.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8
SCAN_DIV, 1000, clocks each digit stays active; legal range >= 1
COMMON_ANODE, 0, 0 = segment and digit outputs active-high; 1 = all of seg, dp and dig_sel inverted

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
d  input  4*NUM_DIGITS  BCD digits; d[3:0] = digit 0 (least significant)
dp_in  input  NUM_DIGITS  decimal point request per digit
le  input  1  latch enable; 0 = load, 1 = hold
bl_n  input  1  blank, active-low
lt_n  input  1  lamp test, active-low
lzb_en  input  1  leading-zero blanking enable
seg  output  7  segments {g,f,e,d,c,b,a}; seg[0] = a
dp  output  1  decimal point for the active digit
dig_sel  output  NUM_DIGITS  one-hot digit enable

Behaviour:
- Single clock domain. rst is synchronous and active-high. All state and outputs update on the rising edge of clk.
- Latch register (4*NUM_DIGITS + NUM_DIGITS bits):
  - le=0: each clock, latch <= {dp_in, d}.
  - le=1: latch holds its value.
  - Reset value: 0.
- Scan counter cnt (0..SCAN_DIV-1) and digit index idx (0..NUM_DIGITS-1):
  - cnt increments every clock.
  - At cnt = SCAN_DIV-1, cnt <= 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
  - SCAN_DIV=1: idx advances every clock.
  - NUM_DIGITS=1: idx stays at 0.
  - Reset: cnt=0, idx=0.
- Outputs are registered, with 1 clock latency from idx, the latch contents and the control inputs.
  - d changes with le=0 reach seg 2 clocks later.
  - lt_n and bl_n changes reach seg 1 clock later, independent of scan position.
- Output reset: seg=off, dp=off, dig_sel=all inactive (polarity applied). The first clock after rst deasserts drives digit 0.
- Decode table for latch nibble N (logical, active-high), 4511 patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7C (no top tail), 7=07, 8=7F, 9=67 (no bottom tail).
  - Codes 10..15 give 00 (blank), matching the 4511.
- Priority per digit, highest first:
  1. lt_n=0: seg=7F and dp=1 for every digit. Overrides bl_n, leading-zero blanking and invalid codes.
  2. bl_n=0: seg=00, dp=0. dig_sel keeps scanning.
  3. Leading-zero blank, when lzb_en=1: digit k is blanked (seg=00) if its nibble and every higher-index nibble are 0. Digit 0 is never blanked, so all zeros displays "0". dp still follows dp_in for a blanked digit.
  4. Normal: seg=decode(N), dp=latched dp_in[idx].
- dig_sel: bit idx active, all others inactive.
- COMMON_ANODE=1 inverts seg, dp and dig_sel at the output register. This includes the reset values, so "off" is driven as 1.
- Reset mid-scan: cnt, idx, latch and outputs return to their reset values on the next clock, regardless of le or lt_n.
- Simultaneous events: an idx advance and a latch load in the same clock take effect together. The next output shows the new idx with the new latch data.

Test Plan:
- Reset/scan (NUM_DIGITS=4, SCAN_DIV=4): hold rst 3 clocks, then release -> dig_sel=0000 during reset; 0001 one clock after release; then 0010, 0100, 1000, 0001 at 4-clock intervals.
- Decode sweep (le=0, lt_n=1, bl_n=1, lzb_en=0): set digit 0 to each value 0..15 -> seg while dig_sel=0001 matches 3F,06,5B,4F,66,6D,7C,07,7F,67, then 00 for codes 10..15.
- Lamp test and blank: lt_n=0, bl_n=0, d=16'hF0F0 -> every digit shows seg=7F, dp=1. Then lt_n=1 -> seg=00, dp=0 one clock later, while dig_sel keeps rotating.
- Latch hold: load d=16'h1234, set le=1, drive d=16'h9999 -> display stays 4,3,2,1 (digit 0..3 = 66,4F,5B,06). Set le=0 -> 9s appear within 2 clocks.
- Leading-zero blanking: d=16'h0050, lzb_en=1 -> digits 3 and 2 give seg=00; digit 1 = 6D; digit 0 = 3F. d=16'h0000 -> only digit 0 shows 3F.
- Polarity (COMMON_ANODE=1): same stimulus as the decode sweep, value 8 -> seg=00, active dig_sel bit = 0. During reset: seg=7F, dig_sel all ones.
